// File: rtl/instr_loader_pkg.sv
// Shared types and helpers for the instruction loader: FSM states, word geometry
// and the header capacity check.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // Word count is widened by two bits before scaling so a large header cannot wrap.
  function automatic logic exceeds_capacity(input logic [31:0] words, input int unsigned mem_bytes);
    logic [33:0] bytes_total;
    bytes_total = {words, 2'b00};
    return bytes_total > 34'(mem_bytes);
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// MSB-first byte packer: collects three bytes and presents the full word
// combinationally together with the byte that completes it.
module instr_loader_byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [23:0] word_reg;
  logic [1:0]  idx_reg;

  assign word_next = {word_reg, byte_in};
  assign word_full = shift && (idx_reg == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (clear) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (shift) begin
      word_reg <= {word_reg[15:0], byte_in};
      idx_reg  <= idx_reg + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed byte stream into instruction memory as big-endian
// words and keeps the CPU in reset until the program is complete.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_BYTES = 40,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst,
  output logic [CNT_W-1:0]  words_written
);

  state_t            state_reg, state_next;
  logic [7:0]        n_hi_reg;
  logic [CNT_W-1:0]  n_reg;
  logic [CNT_W-1:0]  words_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;
  logic              xfer;
  logic              start_ok;
  logic              pack_shift;
  logic              word_full;
  logic [31:0]       word_next;
  logic [CNT_W-1:0]  n_lo_value;
  logic              last_word;

  assign byte_ready = (state_reg == HDR_HI) || (state_reg == HDR_LO) || (state_reg == DATA);
  assign busy       = byte_ready || (state_reg == WRITE);
  assign wr_en      = (state_reg == WRITE);
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERR);
  assign cpu_rst    = (state_reg != DONE);

  assign wr_addr       = wr_addr_reg;
  assign wr_data       = wr_data_reg;
  assign words_written = words_reg;

  assign xfer       = byte_valid && byte_ready;
  assign start_ok   = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
  assign pack_shift = xfer && (state_reg == DATA);
  assign n_lo_value = CNT_W'({n_hi_reg, byte_in});
  assign last_word  = ({1'b0, words_reg} + (CNT_W + 1)'(1)) == {1'b0, n_reg};

  instr_loader_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .shift     (pack_shift),
    .byte_in   (byte_in),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = HDR_HI;
      HDR_HI:  if (xfer) state_next = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (exceeds_capacity(32'(n_lo_value), MEM_BYTES)) state_next = ERR;
          else if (n_lo_value == '0)                          state_next = DONE;
          else                                                state_next = DATA;
        end
      end
      DATA:    if (word_full) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : DATA;
      DONE,
      ERR:     if (start_ok) state_next = HDR_HI;
      default: state_next = IDLE;
    endcase
  end

  // Address and data are captured on the completing byte so they hold steady
  // through the write cycle and keep their value until the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_hi_reg    <= '0;
      n_reg       <= '0;
      words_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      if (start_ok) begin
        words_reg <= '0;
      end else if (state_reg == WRITE) begin
        words_reg <= words_reg + CNT_W'(1);
      end
      if (xfer && (state_reg == HDR_HI)) n_hi_reg <= byte_in;
      if (xfer && (state_reg == HDR_LO)) n_reg <= n_lo_value;
      if (word_full) begin
        wr_addr_reg <= ADDR_W'({words_reg, 2'b00});
        wr_data_reg <= word_next;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a stream model predicts every memory write
// and the end-of-session flags, checked on each write cycle and at session end.
module tb_instr_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst;
  logic [15:0] words_written;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  instr_loader #(.MEM_BYTES(40), .ADDR_W(32), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .cpu_rst       (cpu_rst),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Program image: 16-bit big-endian word count, then 4 bytes per word, MSB first.
  function automatic void model_load(input byte_q_t p, output int n, output bit err);
    n = (int'(p[0]) << 8) | int'(p[1]);
    err = (n * 4) > 40;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        exp_addr.push_back(32'(4 * k));
        exp_data.push_back({p[2+4*k], p[3+4*k], p[4+4*k], p[5+4*k]});
      end
    end
  endfunction

  // Every write cycle must match the next predicted word.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_addr.size() == 0) begin
        chk("unexpected_write", 32'(wr_en), 32'd0);
      end else begin
        chk("wr_addr", wr_addr, exp_addr[0]);
        chk("wr_data", wr_data, exp_data[0]);
        chk("ready_in_write", 32'(byte_ready), 32'd0);
        chk("words_at_write", 32'(words_written), exp_addr[0] >> 2);
        chk("cpu_rst_in_write", 32'(cpu_rst), 32'd1);
        void'(exp_addr.pop_front());
        void'(exp_data.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_in = 8'h5A;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in = b;
    guard = 0;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("handshake_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_bytes(input byte_q_t p, input int first, input int count,
                            input int mode, input int busy_start_idx);
    for (int i = first; i < first + count; i++) begin
      if (i == busy_start_idx) begin
        byte_valid = 1'b0;
        pulse_start();
      end
      send_byte(p[i], (mode == 0) ? 0 : 1 + int'($urandom_range(0, 2)));
    end
  endtask

  task automatic wait_end(input string tag);
    int g;
    g = 0;
    while (!(done || error) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_session_end"}, 32'(done || error), 32'd1);
  endtask

  task automatic run_load(input string tag, input byte_q_t p, input int mode, input int busy_start_idx);
    int n;
    bit err;
    model_load(p, n, err);
    pulse_start();
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_cpu_rst_after_start"}, 32'(cpu_rst), 32'd1);
    send_bytes(p, 0, p.size(), mode, busy_start_idx);
    byte_valid = 1'b0;
    wait_end(tag);
    repeat (2) @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'(!err));
    chk({tag, "_error"}, 32'(error), 32'(err));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_words"}, 32'(words_written), err ? 32'd0 : 32'(n));
    chk({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin
    byte_q_t normal_p;
    byte_q_t big_p;
    byte_q_t one_p;
    byte_q_t empty_p;
    int n;
    bit err;

    normal_p = '{8'h00, 8'h02, 8'hFC, 8'h20, 8'h00, 8'h04, 8'hFC, 8'h40, 8'h00, 8'h03};
    big_p    = '{8'h00, 8'h0B};
    one_p    = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    empty_p  = '{8'h00, 8'h00};

    // Pin the model against hand-computed words.
    model_load(normal_p, n, err);
    chk("model_n", 32'(n), 32'd2);
    chk("model_w0", exp_data[0], 32'hFC200004);
    chk("model_a1", exp_addr[1], 32'd4);
    chk("model_w1", exp_data[1], 32'hFC400003);
    exp_addr.delete();
    exp_data.delete();

    #3;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("idle5");

    run_load("normal", normal_p, 0, -1);
    chk("normal_words_lit", 32'(words_written), 32'd2);
    chk("normal_last_data_held", wr_data, 32'hFC400003);

    run_load("backpressure", normal_p, 1, -1);

    run_load("capacity", big_p, 0, -1);
    run_load("after_err", one_p, 1, -1);
    chk("after_err_data_lit", wr_data, 32'hDEADBEEF);

    run_load("empty", empty_p, 0, -1);

    // Abort a load after the first word and confirm the reset is immediate.
    model_load(normal_p, n, err);
    pulse_start();
    send_bytes(normal_p, 0, 6, 0, -1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_addr.delete();
    exp_data.delete();
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_load("reload_busy_start", normal_p, 0, 5);
    chk("reload_wr_addr_held", wr_addr, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
